// File: rtl/find_max_ctrl.sv
// Purpose: walks n consecutive memory words from start_addr and reports the largest value and its address.
// Latency: done pulses n+2 cycles after the start is accepted (1 cycle for n=0); next start n+3 cycles after.
// Backpressure: none; start is sampled only while idle and is ignored while a scan is in progress.
module find_max_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int N_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [N_W-1:0]    n,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              empty,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_addr
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [N_W-1:0]    N_ONE    = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    // Reads still to issue after the one currently on the bus.
    logic [N_W-1:0]    cnt;
    logic [N_W-1:0]    cnt_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              rd_en_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              accept;

    // Compare pipeline: tracks which returned word belongs to which address.
    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_first;

    // Next-state, next read address and remaining-count computation.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rd_addr_nxt = '0;
        accept      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (n != '0) begin
                        state_nxt   = S_READ;
                        cnt_nxt     = n - N_ONE;
                        rd_addr_nxt = start_addr;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (cnt == '0) begin
                    state_nxt = S_DRAIN;
                end else begin
                    cnt_nxt     = cnt - N_ONE;
                    // Wraps naturally modulo 2^ADDR_W.
                    rd_addr_nxt = rd_addr + ADDR_ONE;
                end
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Outputs are decoded from the next state so they can be registered.
        rd_en_nxt = (state_nxt == S_READ);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state_nxt == S_DONE);
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rd_en   <= rd_en_nxt;
            rd_addr <= rd_addr_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Running maximum: first word loads unconditionally, later words only if strictly larger.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_vld   <= 1'b0;
            cmp_addr  <= '0;
            cmp_first <= 1'b0;
            empty     <= 1'b0;
            max_val   <= '0;
            max_addr  <= '0;
        end else begin
            cmp_vld  <= rd_en;
            cmp_addr <= rd_addr;
            if (accept) begin
                max_val   <= '0;
                max_addr  <= start_addr;
                empty     <= (n == '0);
                cmp_first <= 1'b1;
            end else if (cmp_vld) begin
                if (cmp_first || (rd_data > max_val)) begin
                    max_val  <= rd_data;
                    max_addr <= cmp_addr;
                end
                cmp_first <= 1'b0;
            end
        end
    end

endmodule
